// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage with a per-register write scoreboard and RAW/WAW stall.
// Define OPERAND_FETCH_BYPASS_EN to bypass the writeback bus into the operands.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_en,
    output logic [ADDR_W-1:0] rf_read1,
    output logic [ADDR_W-1:0] rf_read2,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_en
);
    localparam int N = 2 ** ADDR_W;
`ifdef OPERAND_FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    logic [N-1:0] sb, sb_set, sb_clr;
    logic wb_hit1, wb_hit2, raw1, raw2, waw, accept;
    logic [DATA_W-1:0] op1, op2;

    assign rf_read1 = in_rs1;
    assign rf_read2 = in_rs2;
    assign wb_hit1  = wb_valid && wb_reg == in_rs1;
    assign wb_hit2  = wb_valid && wb_reg == in_rs2;
    // Without the bypass a pending source waits until the register file holds the new value.
    assign raw1     = sb[in_rs1] && !(BYP && wb_hit1);
    assign raw2     = sb[in_rs2] && !(BYP && wb_hit2);
    assign waw      = in_rd_en && sb[in_rd] && !(wb_valid && wb_reg == in_rd);
    assign in_ready = (!out_valid || out_ready) && !raw1 && !raw2 && !waw;
    assign accept   = in_valid && in_ready;
    assign op1      = (BYP && wb_hit1) ? wb_data : rf_out1;
    assign op2      = (BYP && wb_hit2) ? wb_data : rf_out2;
    assign sb_set   = (accept && in_rd_en) ? N'(1) << in_rd : '0;
    assign sb_clr   = wb_valid ? N'(1) << wb_reg : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb        <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_en <= 1'b0;
        end else begin
            sb <= (sb & ~sb_clr) | sb_set;
            if (accept) begin
                out_valid <= 1'b1;
                out_op1   <= op1;
                out_op2   <= op2;
                out_rd    <= in_rd;
                out_rd_en <= in_rd_en;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the pipelined 16-bit CPU. Sits between decode and execute and drives the read address ports of the 4-entry register file. It captures both source operands into an output register. A per-register scoreboard tracks in-flight writes; the block stalls decode on RAW and WAW hazards, with optional same-cycle bypass from the writeback bus.

## Interface
Parameters:
- DATA_W, 16, operand/data width
- ADDR_W, 2, register index width (2**ADDR_W registers)

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1, in_rs2  in  ADDR_W  source register indices
- in_rd  in  ADDR_W  destination register index
- in_rd_en  in  1  instruction will write in_rd
- rf_read1, rf_read2  out  ADDR_W  register-file read addresses; combinationally equal to in_rs1 and in_rs2
- rf_out1, rf_out2  in  DATA_W  register-file read data, combinational from rf_read*
- wb_valid  in  1  a writeback is committed this cycle; the register file is written at the same edge
- wb_reg  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- out_valid  out  1  operand register holds a valid instruction
- out_ready  in  1  execute consumes the output this cycle
- out_op1, out_op2  out  DATA_W  captured operands
- out_rd, out_rd_en  out  ADDR_W, 1  forwarded destination info

## Operation
- Scoreboard: one pending bit per register, sb[2**ADDR_W-1:0].
- Set pending bit: on accept (`in_valid && in_ready`) with in_rd_en set, set sb[in_rd].
- Clear pending bit: on wb_valid, clear sb[wb_reg].
  - Next state is `(sb & ~clr) | set`, so set wins if both hit the same index.
  - A writeback to a non-pending register is harmless.
- wb_hit1 / wb_hit2: `wb_valid && wb_reg == in_rs1` (respectively in_rs2).
- RAW hazard on rsN: `sb[rsN] && !(bypass enabled && wb_hitN)`.
- WAW hazard: `in_rd_en && sb[in_rd] && !(wb_valid && wb_reg == in_rd)`.
- Ready rule: `in_ready = (!out_valid || out_ready) && !RAW1 && !RAW2 && !WAW`.
  - in_ready does not depend on in_valid.
- Operand select: opN = wb_data if bypass is enabled and wb_hitN, else rf_outN.
  - The bypass applies even when the register is not pending.
- Output register:
  - On accept, load out_op1, out_op2, out_rd, out_rd_en and set out_valid = 1.
  - Else, if out_ready, clear out_valid; data registers hold their values.
- No FSM beyond the out_valid bit and the scoreboard.

## Timing
- Reset values: out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_en=0, sb=0.
  - In the first cycle after reset, in_ready=1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction per cycle when there are no hazards and out_ready=1.
- Accept and out_ready in the same cycle: the output is replaced and out_valid stays 1 (no bubble).
- Holding rules: while in_valid && !in_ready, decode holds its inputs. While out_valid && !out_ready, the outputs are stable.
- Reset asserted mid-operation: outputs and the scoreboard clear at that edge. Writebacks arriving after reset only clear already-zero bits.
- rs1 == rs2: both operands are taken from the same source.

## Configuration
- OPERAND_FETCH_BYPASS_EN defined:
  - wb_data is bypassed into op1/op2 on wb_hit.
  - A RAW on a register being written back this cycle does not stall.
- Not defined:
  - No bypass mux; opN is always rf_outN.
  - Any RAW on a pending register stalls until the cycle after the writeback, when the register file returns the new value. This costs one extra stall cycle versus the bypass build.

## Test plan
- Reset, then accept rs1=1, rs2=2 with the register file holding 0x1111 and 0x2222, no rd_en:
  - next cycle out_valid=1, out_op1=0x1111, out_op2=0x2222, sb=0.
- Accept an instruction with rd=3, rd_en=1; next present rs1=3:
  - in_ready=0 while sb[3]=1.
  - wb_valid, wb_reg=3, wb_data=0xBEEF with BYPASS_EN: accepted that cycle, out_op1=0xBEEF.
  - Without the macro: accepted one cycle later, out_op1=0xBEEF from the register file.
- WAW: sb[2]=1, present rd=2, rd_en=1:
  - stalls with in_ready=0.
  - On the wb to reg 2 it is accepted and sb[2] ends at 1 (set wins).
- Backpressure: out_valid=1, out_ready=0 for 3 cycles:
  - in_ready=0 and outputs are unchanged.
  - When out_ready=1 with a new accept: out_valid stays 1 with the new operands.
- Back-to-back: 4 independent instructions with out_ready=1 held high:
  - 4 consecutive out_valid cycles.
- Reset asserted while sb=4'b1010 and out_valid=1:
  - next cycle sb=0, out_valid=0, out_op1=0, in_ready=1.
